// File: rtl/cnn_pkg.sv
// Shared CNN front-end defaults and types used by the window mapper and its line buffers.
package cnn_pkg;
  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned IMG_W         = 32;
  localparam int unsigned IMG_H         = 32;
  localparam int unsigned K             = 5;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  localparam int unsigned OUT_W         = IMG_W - K + 1;
  localparam int unsigned OUT_H         = IMG_H - K + 1;
  localparam int unsigned WIN_PER_FRAME = OUT_W * OUT_H;
endpackage

// File: rtl/conv_window_mapper_line_buffer.sv
// One-row delay line: dout is the sample written DEPTH enabled cycles ago.
module line_buffer #(
  parameter int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = cnn_pkg::IMG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  import cnn_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_ptr;

  // Read-before-write at the same slot gives exactly DEPTH transfers of delay.
  assign dout = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (en) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Contents are don't-care after reset, so the storage itself is not cleared.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      r_mem[r_ptr] <= din;
    end
  end
endmodule

// File: rtl/conv_window_mapper.sv
// Raster-order pixel stream to KxK sliding-window mapper feeding the systolic conv array.
// Optional feature: define MAPPER_LAST_EN to add the win_last end-of-frame flag.
module conv_window_mapper #(
  parameter int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int unsigned IMG_W      = cnn_pkg::IMG_W,
  parameter int unsigned IMG_H      = cnn_pkg::IMG_H,
  parameter int unsigned K          = cnn_pkg::K
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_pixel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [K*K*DATA_WIDTH-1:0] win,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic                      frame_done
`ifdef MAPPER_LAST_EN
  ,
  output logic                      win_last
`endif
);
  import cnn_pkg::*;

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic [DATA_WIDTH-1:0]     r_win   [K][K];
  logic [DATA_WIDTH-1:0]     w_shift [K][K];
  logic [DATA_WIDTH-1:0]     w_lb_out [K-1];
  logic [K*K*DATA_WIDTH-1:0] w_flat;
  logic [K*K*DATA_WIDTH-1:0] r_win_out;
  logic                      r_win_valid;
  logic                      r_frame_done;
  logic                      w_px_xfer;
  logic                      w_col_last;
  logic                      w_row_last;
  logic                      w_emit;
`ifdef MAPPER_LAST_EN
  logic                      r_win_last;
`endif

  assign in_ready   = !r_win_valid || win_ready;
  assign w_px_xfer  = in_valid && in_ready;
  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_emit     = w_px_xfer && (r_row >= ROW_W'(K - 1)) && (r_col >= COL_W'(K - 1));

  assign win        = r_win_out;
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;
`ifdef MAPPER_LAST_EN
  assign win_last   = r_win_last;
`endif

  // Buffer j delays by j+1 rows; its output feeds window row K-2-j.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    logic [DATA_WIDTH-1:0] w_din;
    if (j == 0) begin : g_head
      assign w_din = in_pixel;
    end else begin : g_tail
      assign w_din = w_lb_out[j-1];
    end
    line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_W)
    ) u_lb (
      .clk (clk),
      .rst (rst),
      .en  (w_px_xfer),
      .din (w_din),
      .dout(w_lb_out[j])
    );
  end

  always_comb begin
    w_flat = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        w_shift[r][c] = r_win[r][c+1];
      end
    end
    for (int unsigned r = 0; r < K - 1; r++) begin
      w_shift[r][K-1] = w_lb_out[K-2-r];
    end
    w_shift[K-1][K-1] = in_pixel;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        w_flat[(r*K + c)*DATA_WIDTH +: DATA_WIDTH] = w_shift[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win        <= '{default: '0};
      r_win_out    <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef MAPPER_LAST_EN
      r_win_last   <= 1'b0;
`endif
    end else begin
      r_frame_done <= w_px_xfer && w_col_last && w_row_last;
      if (w_px_xfer) begin
        r_win <= w_shift;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_emit) begin
        r_win_out   <= w_flat;
        r_win_valid <= 1'b1;
`ifdef MAPPER_LAST_EN
        r_win_last  <= w_col_last && w_row_last;
`endif
      end else if (r_win_valid && win_ready) begin
        r_win_valid <= 1'b0;
`ifdef MAPPER_LAST_EN
        r_win_last  <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_conv_window_mapper.sv
// Self-checking bench for conv_window_mapper against a frame-level window model.
module tb_conv_window_mapper;
  import cnn_pkg::*;

  localparam int unsigned WIN_BITS  = K * K * DATA_WIDTH;
  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
  typedef logic [WIN_BITS-1:0] win_t;

  logic   clk = 1'b0;
  logic   rst;
  pixel_t in_pixel;
  logic   in_valid;
  logic   in_ready;
  win_t   win;
  logic   win_valid;
  logic   win_ready;
  logic   frame_done;
`ifdef MAPPER_LAST_EN
  logic   win_last;
`endif

  always #5 clk = ~clk;

  conv_window_mapper #(
    .DATA_WIDTH(DATA_WIDTH),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .K         (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win       (win),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .frame_done(frame_done)
`ifdef MAPPER_LAST_EN
    ,
    .win_last  (win_last)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pixel_t      src_q[$];
  win_t        rx_q[$];
  bit          rx_last_q[$];
  win_t        exp_q[$];
  int unsigned fd_cnt;
  bit          fd_bad;
  bit          timed_out;
  win_t        stall_ref;
  bit          stall_stable[3];
  logic        stall_inrdy[3];
  logic        stall_last[3];
  int unsigned stall_n;

  // Window at output (oy,ox) is the KxK block of the frame whose top-left pixel is (oy,ox).
  function automatic void build_expected(input int unsigned nframes);
    win_t w;
    exp_q.delete();
    for (int unsigned f = 0; f < nframes; f++)
      for (int unsigned oy = 0; oy < OUT_H; oy++)
        for (int unsigned ox = 0; ox < OUT_W; ox++) begin
          w = '0;
          for (int unsigned r = 0; r < K; r++)
            for (int unsigned c = 0; c < K; c++)
              w[(r*K + c)*DATA_WIDTH +: DATA_WIDTH] = src_q[f*FRAME_PIX + (oy + r)*IMG_W + ox + c];
          exp_q.push_back(w);
        end
  endfunction

  function automatic pixel_t elem(input win_t w, input int unsigned e);
    return w[e*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic void load_ramp(input int unsigned offset);
    for (int unsigned i = 0; i < FRAME_PIX; i++) src_q.push_back(pixel_t'(i + offset));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams src_q into the DUT, collecting every transferred window; stall_at >= 0
  // holds win_ready low for 3 cycles while that window index is presented.
  task automatic drive(input int unsigned vpct, input int unsigned rpct, input int stall_at);
    int unsigned idx = 0, cyc = 0, idle = 0, limit;
    bit wr, stalling;
    rx_q.delete(); rx_last_q.delete();
    fd_cnt = 0; fd_bad = 0; timed_out = 0; stall_n = 0;
    limit = 20 * src_q.size() + 200;
    while (idx < src_q.size() || idle < 6) begin
      @(negedge clk);
      if (frame_done) begin
        fd_cnt++;
        if (!win_valid) fd_bad = 1;
      end
      in_valid = (idx < src_q.size()) && ($urandom_range(99) < vpct);
      in_pixel = in_valid ? src_q[idx] : pixel_t'($urandom);
      wr = (idx >= src_q.size()) || ($urandom_range(99) < rpct);
      stalling = (stall_at >= 0) && (rx_q.size() == stall_at) && win_valid && (stall_n < 3);
      if (stalling) begin
        if (stall_n == 0) stall_ref = win;
        wr = 1'b0;
        in_valid = (idx < src_q.size());
        if (in_valid) in_pixel = src_q[idx];
      end
      win_ready = wr;
      #1;
      if (stalling) begin
        stall_stable[stall_n] = (win === stall_ref) && (win_valid === 1'b1);
        stall_inrdy[stall_n]  = in_ready;
`ifdef MAPPER_LAST_EN
        stall_last[stall_n]   = win_last;
`else
        stall_last[stall_n]   = 1'b0;
`endif
        stall_n++;
      end
      if (win_valid && win_ready) begin
        rx_q.push_back(win);
`ifdef MAPPER_LAST_EN
        rx_last_q.push_back(win_last);
`else
        rx_last_q.push_back(1'b0);
`endif
      end
      if (in_valid && in_ready) idx++;
      if (idx >= src_q.size()) idle++;
      cyc++;
      if (cyc > limit) begin
        timed_out = 1;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0; in_pixel = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid got %b want 0", win_valid); else n_pass++;
    n_checks++; if (win !== '0) $display("FAIL reset_win got %h want 0", win); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
`ifdef MAPPER_LAST_EN
    n_checks++; if (win_last !== 1'b0) $display("FAIL reset_win_last got %b want 0", win_last); else n_pass++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    do_reset();
    src_q.delete(); load_ramp(0);
    drive(100, 100, -1);
    build_expected(1);
    n_checks++; if (timed_out) $display("FAIL ramp_timeout got windows=%0d want %0d", rx_q.size(), WIN_PER_FRAME); else n_pass++;
    n_checks++; if (rx_q.size() != WIN_PER_FRAME) $display("FAIL ramp_count got %0d want %0d", rx_q.size(), WIN_PER_FRAME); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL ramp_frame_done_count got %0d want 1", fd_cnt); else n_pass++;
    n_checks++; if (fd_bad) $display("FAIL ramp_frame_done_with_valid got 0 want 1"); else n_pass++;
    if (rx_q.size() > 0) begin
      n_checks++; if (elem(rx_q[0], 0) !== 16'd0) $display("FAIL ramp_first_e0 got %0d want 0", elem(rx_q[0], 0)); else n_pass++;
      n_checks++; if (elem(rx_q[0], 4) !== 16'd4) $display("FAIL ramp_first_e4 got %0d want 4", elem(rx_q[0], 4)); else n_pass++;
      n_checks++; if (elem(rx_q[0], 5) !== 16'd32) $display("FAIL ramp_first_e5 got %0d want 32", elem(rx_q[0], 5)); else n_pass++;
      n_checks++; if (elem(rx_q[0], 24) !== 16'd132) $display("FAIL ramp_first_e24 got %0d want 132", elem(rx_q[0], 24)); else n_pass++;
      n_checks++; if (elem(rx_q[rx_q.size()-1], 0) !== 16'd891) $display("FAIL ramp_last_e0 got %0d want 891", elem(rx_q[rx_q.size()-1], 0)); else n_pass++;
      n_checks++; if (elem(rx_q[rx_q.size()-1], 24) !== 16'd1023) $display("FAIL ramp_last_e24 got %0d want 1023", elem(rx_q[rx_q.size()-1], 24)); else n_pass++;
    end
    for (int unsigned i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL ramp_win[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    src_q.delete(); load_ramp(0);
    drive(100, 100, 10);
    build_expected(1);
    n_checks++; if (stall_n != 3) $display("FAIL bp_stall_cycles got %0d want 3", stall_n); else n_pass++;
    for (int unsigned s = 0; s < 3; s++) begin
      n_checks++; if (stall_inrdy[s] !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", s, stall_inrdy[s]); else n_pass++;
    end
    for (int unsigned s = 1; s < 3; s++) begin
      n_checks++; if (!stall_stable[s]) $display("FAIL bp_win_stable[%0d] got changed want held", s); else n_pass++;
    end
    n_checks++; if (rx_q.size() != WIN_PER_FRAME) $display("FAIL bp_count got %0d want %0d", rx_q.size(), WIN_PER_FRAME); else n_pass++;
    for (int unsigned i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL bp_win[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    src_q.delete();
    for (int unsigned i = 0; i < 100; i++) src_q.push_back(pixel_t'($urandom));
    drive(100, 100, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (win_valid !== 1'b0) $display("FAIL midrst_win_valid got %b want 0", win_valid); else n_pass++;
    rst = 1'b0;
    src_q.delete(); load_ramp(0);
    drive(100, 100, -1);
    build_expected(1);
    n_checks++; if (rx_q.size() != WIN_PER_FRAME) $display("FAIL midrst_count got %0d want %0d", rx_q.size(), WIN_PER_FRAME); else n_pass++;
    if (rx_q.size() > 0) begin
      n_checks++; if (elem(rx_q[0], 24) !== 16'd132) $display("FAIL midrst_first_e24 got %0d want 132", elem(rx_q[0], 24)); else n_pass++;
    end
    for (int unsigned i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL midrst_win[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    src_q.delete(); load_ramp(0); load_ramp(2000);
    drive(100, 100, -1);
    build_expected(2);
    n_checks++; if (rx_q.size() != 2*WIN_PER_FRAME) $display("FAIL b2b_count got %0d want %0d", rx_q.size(), 2*WIN_PER_FRAME); else n_pass++;
    n_checks++; if (fd_cnt != 2) $display("FAIL b2b_frame_done_count got %0d want 2", fd_cnt); else n_pass++;
    if (rx_q.size() > WIN_PER_FRAME) begin
      n_checks++; if (elem(rx_q[WIN_PER_FRAME], 0) !== 16'd2000) $display("FAIL b2b_f2_e0 got %0d want 2000", elem(rx_q[WIN_PER_FRAME], 0)); else n_pass++;
      n_checks++; if (elem(rx_q[WIN_PER_FRAME], 24) !== 16'd2132) $display("FAIL b2b_f2_e24 got %0d want 2132", elem(rx_q[WIN_PER_FRAME], 24)); else n_pass++;
    end
    for (int unsigned i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL b2b_win[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random_gaps();
    do_reset();
    src_q.delete();
    for (int unsigned i = 0; i < FRAME_PIX; i++) src_q.push_back(pixel_t'($urandom));
    drive(50, 50, -1);
    build_expected(1);
    n_checks++; if (timed_out) $display("FAIL gaps_timeout got windows=%0d want %0d", rx_q.size(), WIN_PER_FRAME); else n_pass++;
    n_checks++; if (rx_q.size() != WIN_PER_FRAME) $display("FAIL gaps_count got %0d want %0d", rx_q.size(), WIN_PER_FRAME); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL gaps_frame_done_count got %0d want 1", fd_cnt); else n_pass++;
    for (int unsigned i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i] !== exp_q[i]) $display("FAIL gaps_win[%0d] got %h want %h", i, rx_q[i], exp_q[i]); else n_pass++;
    end
  endtask

`ifdef MAPPER_LAST_EN
  task automatic test_last();
    int unsigned n_high = 0, hi_idx = 0;
    do_reset();
    src_q.delete(); load_ramp(0);
    drive(100, 100, WIN_PER_FRAME - 1);
    foreach (rx_last_q[i]) if (rx_last_q[i]) begin n_high++; hi_idx = i; end
    n_checks++; if (n_high != 1) $display("FAIL last_count got %0d want 1", n_high); else n_pass++;
    n_checks++; if (hi_idx != WIN_PER_FRAME - 1) $display("FAIL last_index got %0d want %0d", hi_idx, WIN_PER_FRAME - 1); else n_pass++;
    for (int unsigned s = 0; s < 3; s++) begin
      n_checks++; if (stall_last[s] !== 1'b1) $display("FAIL last_stall[%0d] got %b want 1", s, stall_last[s]); else n_pass++;
    end
  endtask
`endif

  initial begin
    rst = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_pixel = '0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random_gaps();
`ifdef MAPPER_LAST_EN
    test_last();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_window_mapper.md
# conv_window_mapper

Streaming image-to-window mapper that sits directly upstream of the systolic convolution array. It accepts one pixel per handshake in raster order (row-major, 32x32 by default) and emits, for every valid output position, the full KxK receptive-field window as a flat vector. The systolic array multiplies each window against the loaded filter weights. A frame of 1024 pixels produces (IMG_H-K+1)x(IMG_W-K+1) = 784 windows in raster order of output position.

## Interface
- DATA_WIDTH, 16, pixel width in bits
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in pixels
- K, 5, square kernel dimension; window holds K*K pixels
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_pixel  in  DATA_WIDTH  pixel, taken from the low bits of the 32-bit AXI input word
- in_valid  in  1  in_pixel is valid this cycle
- in_ready  out  1  mapper can accept a pixel this cycle
- win  out  K*K*DATA_WIDTH  window; element e = r*K+c occupies bits [e*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top (oldest) row, c=0 is the leftmost column
- win_valid  out  1  win holds a window
- win_ready  in  1  downstream accepts win this cycle
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Pixel transfer happens when in_valid && in_ready.
- Window transfer happens when win_valid && win_ready.
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) track the position of the next pixel.
  - On each pixel transfer, col increments.
  - When col reaches IMG_W-1, col wraps to 0 and row increments.
  - When row reaches IMG_H-1 and col reaches IMG_W-1, both wrap to 0 and frame_done pulses next cycle.
- Storage:
  - K-1 line buffers, each IMG_W deep, hold the previous K-1 rows.
  - A KxK register window shifts left by one column per accepted pixel.
  - The new right column is filled from the line-buffer outputs (top rows) and from in_pixel (bottom row, r=K-1).
- Window emission: a pixel accepted at (row, col) with row >= K-1 and col >= K-1 loads the output register.
  - win takes the shifted window, with that pixel at e = K*K-1.
  - win_valid is set.
  - Positions with col < K-1 or row < K-1 shift the window but emit nothing.
  - Windows therefore never straddle a row boundary.
- Output register: a single stage.
  - in_ready = !win_valid || win_ready (combinational).
  - win_valid clears on a transfer that is not accompanied by a new emission.
- Arithmetic: pixels pass through unmodified and are never widened or truncated. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.
- Frames run back-to-back with no gap. Line-buffer contents from the previous frame are don't-care, because no window is emitted until K-1 rows of the new frame have been accepted.
- Reset mid-frame: counters, window, and output register clear. The next accepted pixel is treated as (0,0). Windows not yet transferred are discarded.

## Timing
- Reset values:
  - win_valid = 0
  - win = 0
  - frame_done = 0
  - counters = 0
  - in_ready = 1
- Latency: win_valid rises 1 cycle after the transfer of the emitting pixel.
- Throughput: 1 pixel/cycle and 1 window/cycle when win_ready is held high.
- Backpressure:
  - While win_valid && !win_ready, win must stay stable, in_ready = 0, and no internal state changes.
  - A pixel presented with in_valid under backpressure is held by the sender and not lost.
- Simultaneous window transfer and new pixel transfer in the same cycle: the output register is overwritten and win_valid stays high.
- in_valid low: nothing advances; the window holds.
- frame_done is asserted in the cycle after the (IMG_H-1, IMG_W-1) pixel transfer. This coincides with win_valid for the final window.

## Configuration
- MAPPER_LAST_EN defined:
  - Adds output win_last (1 bit, reset 0), registered alongside win.
  - win_last is high with the final window of each frame (output position (IMG_H-K, IMG_W-K)).
  - win_last is held stable under backpressure.
- MAPPER_LAST_EN undefined: the win_last port does not exist. All other behaviour is identical.

## Structure
- Shared package cnn_pkg holds:
  - DATA_WIDTH, K, IMG_W, IMG_H defaults
  - typedef logic [DATA_WIDTH-1:0] pixel_t
  - localparam OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1, WIN_PER_FRAME = OUT_W*OUT_H
- Sub-module line_buffer: IMG_W-deep, DATA_WIDTH-wide delay line.
  - Advances only on an enable input (the pixel transfer).
  - Clears its pointer on rst.
  - Instantiated K-1 times in a chain.

## Test plan
- Ramp frame (pixel i = i, i = 0..1023) with win_ready = 1:
  - first window follows pixel 132, with win[0]=0, win[4]=4, win[5]=32, win[24]=132
  - last window has win[0]=891, win[24]=1023
  - exactly 784 windows
  - frame_done pulses once
- Backpressure: hold win_ready low for 3 cycles at window 10 -> win is unchanged, in_ready = 0, all 784 windows are still received in order with none duplicated.
- Reset asserted after 100 pixels, then a full ramp frame -> 784 windows with values identical to the first test, and no stale window after reset.
- Two back-to-back frames (frame 2 = ramp + 2000) -> 1568 windows, frame_done pulses twice, frame 2 first window has win[0]=2000 and win[24]=2132.
- Random in_valid and win_ready gaps (≈50%) -> the window sequence matches the gap-free run exactly.
- With MAPPER_LAST_EN: win_last is high only on window 784 (win[24]=1023) and stays high while stalled under backpressure.
